// File: rtl/decode_stage_hz.sv
// rtl/decode_stage_hz.sv - decode stage: register file with write bypass, load-use hazard stall, ID/EX register
// Stall is purely combinational from the registered execute slot; a flush or stall turns the slot into a bubble.
module decode_stage_hz #(
   parameter int XLEN    = 32,
   parameter int REG_CNT = 32,
   parameter int CTRL_W  = 12,
   localparam int AW     = $clog2(REG_CNT)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       InstrD,
   input  logic [XLEN-1:0]   PCD,
   input  logic [XLEN-1:0]   PCPlus4D,
   input  logic [XLEN-1:0]   ImmExtD,
   input  logic [CTRL_W-1:0] CtrlD,
   input  logic              ValidD,
   input  logic              FlushE,
   input  logic              RegWriteW,
   input  logic [AW-1:0]     RDW,
   input  logic [XLEN-1:0]   ResultW,
   output logic [CTRL_W-1:0] CtrlE,
   output logic [XLEN-1:0]   RD1_E,
   output logic [XLEN-1:0]   RD2_E,
   output logic [XLEN-1:0]   Imm_Ext_E,
   output logic [XLEN-1:0]   PCE,
   output logic [XLEN-1:0]   PCPlus4E,
   output logic [AW-1:0]     RS1_E,
   output logic [AW-1:0]     RS2_E,
   output logic [AW-1:0]     RD_E,
   output logic              ValidE,
   output logic              StallD,
   output logic [15:0]       BubbleCnt
);

   logic [XLEN-1:0] regFile [REG_CNT];
   logic [AW-1:0]   rs1, rs2, rd;
   logic [XLEN-1:0] rd1, rd2;
   logic            wbWrite;
   logic            bubble;
   logic            unusedInstr;

   assign rs1 = InstrD[15 +: AW];
   assign rs2 = InstrD[20 +: AW];
   assign rd  = InstrD[7 +: AW];
   // Only the register fields are decoded here; the rest of the word belongs to other units.
   assign unusedInstr = ^InstrD;

   assign wbWrite = RegWriteW && (RDW != '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < REG_CNT; i++) regFile[i] <= '0;
      end else if (wbWrite) begin
         regFile[RDW] <= ResultW;
      end
   end

   // Writeback bypass lets a decode read see the value being written this very cycle.
   always_comb begin
      rd1 = regFile[rs1];
      if (rs1 == '0)
         rd1 = '0;
      else if (wbWrite && (RDW == rs1))
         rd1 = ResultW;
   end

   always_comb begin
      rd2 = regFile[rs2];
      if (rs2 == '0)
         rd2 = '0;
      else if (wbWrite && (RDW == rs2))
         rd2 = ResultW;
   end

   assign StallD = ValidD && ValidE && CtrlE[1] && (RD_E != '0) &&
                   ((RD_E == rs1) || (RD_E == rs2));
   assign bubble = FlushE || StallD;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         CtrlE     <= '0;
         RD1_E     <= '0;
         RD2_E     <= '0;
         Imm_Ext_E <= '0;
         PCE       <= '0;
         PCPlus4E  <= '0;
         RS1_E     <= '0;
         RS2_E     <= '0;
         RD_E      <= '0;
         ValidE    <= 1'b0;
      end else if (bubble) begin
         // Datapath fields keep their old values; only the control side is squashed.
         CtrlE  <= '0;
         ValidE <= 1'b0;
      end else begin
         ValidE    <= ValidD;
         CtrlE     <= ValidD ? CtrlD : '0;
         RD1_E     <= rd1;
         RD2_E     <= rd2;
         Imm_Ext_E <= ImmExtD;
         PCE       <= PCD;
         PCPlus4E  <= PCPlus4D;
         RS1_E     <= rs1;
         RS2_E     <= rs2;
         RD_E      <= rd;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         BubbleCnt <= '0;
      else if (bubble && (BubbleCnt != 16'hFFFF))
         BubbleCnt <= BubbleCnt + 16'd1;
   end

endmodule

// File: tb/tb_decode_stage_hz.sv
// tb/tb_decode_stage_hz.sv - bench for decode_stage_hz: directed vector table, random traffic against a reference model
module tb_decode_stage_hz;

   logic        clk, rst;
   logic [31:0] InstrD, PCD, PCPlus4D, ImmExtD, ResultW;
   logic [11:0] CtrlD, CtrlE;
   logic        ValidD, FlushE, RegWriteW, ValidE, StallD;
   logic [4:0]  RDW, RS1_E, RS2_E, RD_E;
   logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
   logic [15:0] BubbleCnt;

   decode_stage_hz dut (
      .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
      .ImmExtD(ImmExtD), .CtrlD(CtrlD), .ValidD(ValidD), .FlushE(FlushE),
      .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .CtrlE(CtrlE),
      .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE),
      .PCPlus4E(PCPlus4E), .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E),
      .ValidE(ValidE), .StallD(StallD), .BubbleCnt(BubbleCnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [4:0]  tRs1, tRs2, tRd, tRdw;
   logic [11:0] tCtrl;
   logic        tVd, tFl, tWe;
   logic [31:0] tRes, tPc, tImm;
   logic [16:0] tJunk;

   assign InstrD    = {tJunk[16:10], tRs2, tRs1, tJunk[9:7], tRd, tJunk[6:0]};
   assign PCD       = tPc;
   assign PCPlus4D  = tPc + 32'd4;
   assign ImmExtD   = tImm;
   assign CtrlD     = tCtrl;
   assign ValidD    = tVd;
   assign FlushE    = tFl;
   assign RegWriteW = tWe;
   assign RDW       = tRdw;
   assign ResultW   = tRes;

   int nVec = 0;
   int nMiss = 0;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      nVec++;
      if (got !== exp) begin
         nMiss++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // Reference model: architectural register contents plus what the execute slot should hold.
   logic [31:0] mRegs [32];
   logic        mValidE, mStall, sStall;
   logic [11:0] mCtrlE;
   logic [31:0] mRd1, mRd2, mImm, mPc, mPc4;
   logic [4:0]  mRs1, mRs2, mRd;
   logic [15:0] mBub;

   task automatic modelReset();
      for (int i = 0; i < 32; i++) mRegs[i] = 32'd0;
      mValidE = 1'b0; mCtrlE = 12'd0; mRd1 = 32'd0; mRd2 = 32'd0; mImm = 32'd0;
      mPc = 32'd0; mPc4 = 32'd0; mRs1 = 5'd0; mRs2 = 5'd0; mRd = 5'd0; mBub = 16'd0;
      mStall = 1'b0;
   endtask

   function automatic logic [31:0] rdVal(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (tWe && tRdw == a) return tRes;
      return mRegs[a];
   endfunction

   task automatic step();
      logic [31:0] a, b;
      @(negedge clk);
      sStall = StallD;
      mStall = tVd && mValidE && mCtrlE[1] && (mRd != 5'd0) && (mRd == tRs1 || mRd == tRs2);
      a = rdVal(tRs1);
      b = rdVal(tRs2);
      if (tFl || mStall) begin
         mValidE = 1'b0;
         mCtrlE  = 12'd0;
         if (mBub != 16'hFFFF) mBub = mBub + 16'd1;
      end else begin
         mValidE = tVd;
         mCtrlE  = tVd ? tCtrl : 12'd0;
         mRd1 = a; mRd2 = b; mImm = tImm; mPc = tPc; mPc4 = tPc + 32'd4;
         mRs1 = tRs1; mRs2 = tRs2; mRd = tRd;
      end
      if (tWe && tRdw != 5'd0) mRegs[tRdw] = tRes;
      @(posedge clk);
      #1;
   endtask

   task automatic checkModel(input string tag);
      chk({tag, ".stall"}, 64'(sStall), 64'(mStall));
      chk({tag, ".validE"}, 64'(ValidE), 64'(mValidE));
      chk({tag, ".ctrlE"}, 64'(CtrlE), 64'(mCtrlE));
      chk({tag, ".rd1"}, 64'(RD1_E), 64'(mRd1));
      chk({tag, ".rd2"}, 64'(RD2_E), 64'(mRd2));
      chk({tag, ".imm"}, 64'(Imm_Ext_E), 64'(mImm));
      chk({tag, ".pc"}, 64'(PCE), 64'(mPc));
      chk({tag, ".pc4"}, 64'(PCPlus4E), 64'(mPc4));
      chk({tag, ".rs"}, 64'({RS1_E, RS2_E, RD_E}), 64'({mRs1, mRs2, mRd}));
      chk({tag, ".bub"}, 64'(BubbleCnt), 64'(mBub));
   endtask

   task automatic randDecode();
      logic [31:0] r;
      r = $urandom;
      tRs1 = {2'b00, r[2:0]};
      tRs2 = {2'b00, r[5:3]};
      tRd  = {2'b00, r[8:6]};
      tVd  = (r[12:9] != 4'd0);
      tCtrl = $urandom;
      tJunk = $urandom;
      tImm = $urandom;
      tPc  = {$urandom, 2'b00};
   endtask

   typedef struct {
      logic [4:0]  rs1, rs2, rd;
      logic [11:0] ctrl;
      logic        vd, fl, we;
      logic [4:0]  rdw;
      logic [31:0] res, pc;
      logic        eStall, eValid;
      logic [11:0] eCtrl;
      logic [4:0]  eRd;
      logic [31:0] eRd1, eRd2, ePc;
      logic [15:0] eBub;
   } vec_t;

   vec_t vt [8];

   initial begin
      // Bypassed write of x5, load to x7, load-use bubble, load to x0, x0 reader, flush, invalid slot.
      vt[0] = '{5'd5, 5'd0, 5'd1, 12'h001, 1'b1, 1'b0, 1'b1, 5'd5, 32'h1234, 32'h100,
                1'b0, 1'b1, 12'h001, 5'd1, 32'h1234, 32'h0, 32'h100, 16'd0};
      vt[1] = '{5'd5, 5'd0, 5'd7, 12'h003, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h104,
                1'b0, 1'b1, 12'h003, 5'd7, 32'h1234, 32'h0, 32'h104, 16'd0};
      vt[2] = '{5'd0, 5'd7, 5'd2, 12'h001, 1'b1, 1'b0, 1'b1, 5'd7, 32'hBEEF, 32'h108,
                1'b1, 1'b0, 12'h000, 5'd7, 32'h1234, 32'h0, 32'h104, 16'd1};
      vt[3] = '{5'd0, 5'd7, 5'd2, 12'h001, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h108,
                1'b0, 1'b1, 12'h001, 5'd2, 32'h0, 32'hBEEF, 32'h108, 16'd1};
      vt[4] = '{5'd5, 5'd0, 5'd0, 12'h003, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h10C,
                1'b0, 1'b1, 12'h003, 5'd0, 32'h1234, 32'h0, 32'h10C, 16'd1};
      vt[5] = '{5'd0, 5'd0, 5'd3, 12'h001, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h110,
                1'b0, 1'b1, 12'h001, 5'd3, 32'h0, 32'h0, 32'h110, 16'd1};
      vt[6] = '{5'd5, 5'd0, 5'd4, 12'h001, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 32'h114,
                1'b0, 1'b0, 12'h000, 5'd3, 32'h0, 32'h0, 32'h110, 16'd2};
      vt[7] = '{5'd5, 5'd0, 5'd6, 12'h0FF, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h118,
                1'b0, 1'b0, 12'h000, 5'd6, 32'h1234, 32'h0, 32'h118, 16'd2};

      tRs1 = 5'd0; tRs2 = 5'd0; tRd = 5'd0; tRdw = 5'd0; tCtrl = 12'd0;
      tVd = 1'b0; tFl = 1'b0; tWe = 1'b0; tRes = 32'd0; tPc = 32'd0; tImm = 32'd0;
      tJunk = 17'd0;
      modelReset();
      rst = 1'b0;
      #3;
      chk("rst.validE", 64'(ValidE), 64'd0);
      chk("rst.ctrlE", 64'(CtrlE), 64'd0);
      chk("rst.bub", 64'(BubbleCnt), 64'd0);
      chk("rst.pc", 64'(PCE), 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;

      for (int i = 0; i < 8; i++) begin
         tRs1 = vt[i].rs1; tRs2 = vt[i].rs2; tRd = vt[i].rd; tCtrl = vt[i].ctrl;
         tVd = vt[i].vd; tFl = vt[i].fl; tWe = vt[i].we; tRdw = vt[i].rdw;
         tRes = vt[i].res; tPc = vt[i].pc;
         step();
         chk($sformatf("v%0d.stall", i), 64'(sStall), 64'(vt[i].eStall));
         chk($sformatf("v%0d.validE", i), 64'(ValidE), 64'(vt[i].eValid));
         chk($sformatf("v%0d.ctrlE", i), 64'(CtrlE), 64'(vt[i].eCtrl));
         chk($sformatf("v%0d.rdE", i), 64'(RD_E), 64'(vt[i].eRd));
         chk($sformatf("v%0d.rd1", i), 64'(RD1_E), 64'(vt[i].eRd1));
         chk($sformatf("v%0d.rd2", i), 64'(RD2_E), 64'(vt[i].eRd2));
         chk($sformatf("v%0d.pc", i), 64'(PCE), 64'(vt[i].ePc));
         chk($sformatf("v%0d.bub", i), 64'(BubbleCnt), 64'(vt[i].eBub));
      end

      // Random traffic; decode inputs are held whenever the previous cycle stalled.
      for (int i = 0; i < 400; i++) begin
         logic [31:0] r;
         if (!mStall) randDecode();
         r = $urandom;
         tFl  = (r[3:0] == 4'd0);
         tWe  = r[4];
         tRdw = {2'b00, r[7:5]};
         tRes = $urandom;
         step();
         checkModel("rnd");
      end

      tWe = 1'b0;
      for (int n = 0; n < 70000 && mBub != 16'hFFFE; n++) begin
         randDecode();
         tFl = 1'b1;
         step();
      end
      chk("sat.pre", 64'(BubbleCnt), 64'hFFFE);
      for (int i = 0; i < 3; i++) begin
         randDecode();
         tFl = 1'b1;
         step();
         checkModel("sat");
         chk("sat.cnt", 64'(BubbleCnt), 64'hFFFF);
      end

      tFl = 1'b0; tVd = 1'b1; tRs1 = 5'd1; tRs2 = 5'd2; tRd = 5'd7; tCtrl = 12'h003;
      step();
      checkModel("ld");
      tRs1 = 5'd7; tRd = 5'd3; tCtrl = 12'h001;
      #1;
      chk("mid.stall", 64'(StallD), 64'd1);
      rst = 1'b0;
      #1;
      modelReset();
      chk("arst.stall", 64'(StallD), 64'd0);
      chk("arst.validE", 64'(ValidE), 64'd0);
      chk("arst.ctrlE", 64'(CtrlE), 64'd0);
      chk("arst.data", 64'(RD1_E | RD2_E | Imm_Ext_E | PCE | PCPlus4E), 64'd0);
      chk("arst.rs", 64'({RS1_E, RS2_E, RD_E}), 64'd0);
      chk("arst.bub", 64'(BubbleCnt), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      tWe = 1'b1; tRdw = 5'd0; tRes = 32'hFFFF_FFFF; tRs1 = 5'd0; tRs2 = 5'd5;
      tCtrl = 12'h001; tPc = 32'h200;
      step();
      checkModel("post");
      chk("post.validE", 64'(ValidE), 64'd1);
      tWe = 1'b0; tPc = 32'h204;
      step();
      checkModel("post2");
      chk("post.x0", 64'(RD1_E), 64'd0);
      chk("post.x5", 64'(RD2_E), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
      $finish;
   end

endmodule
